// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor: widths, instruction field
// positions, the HALT opcode and the fetch-stage state encoding.
package cpu_pkg;

    localparam int PC_W    = 4;
    localparam int INSTR_W = 8;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;

    localparam logic [3:0] OPC_HALT = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: synchronous reset, jump load, increment or hold.
// A load takes precedence over an increment.
module pc_reg #(
    parameter int              PC_W     = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic [PC_W-1:0] load_val_i,
    input  logic            inc_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Increment wraps naturally at 2^PC_W with no carry out.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures instructions into the IR and
// hands them to the decoder over valid/ready; supports start, jump and halt.
module fetch_unit #(
    parameter int                 PC_W     = cpu_pkg::PC_W,
    parameter int                 INSTR_W  = cpu_pkg::INSTR_W,
    parameter logic [PC_W-1:0]    RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    output logic [PC_W-1:0]    pc_o,
    input  logic [INSTR_W-1:0] instr_i,
    output logic [INSTR_W-1:0] ir_o,
    output logic               ir_valid_o,
    input  logic               ir_ready_i,
    input  logic               jump_en_i,
    input  logic [PC_W-1:0]    jump_addr_i,
    output logic               halted_o
);

    import cpu_pkg::*;

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic [INSTR_W-1:0] ir_q;
    logic [INSTR_W-1:0] ir_d;
    logic               ir_valid_q;
    logic               ir_valid_d;

    logic jump_act;
    logic load;
    logic transfer;
    logic is_halt;
    logic pc_inc;

    // Jumps only act once fetching has started; IDLE ignores them.
    always_comb begin
        jump_act = jump_en_i && (state_q != ST_IDLE);
        load     = (state_q == ST_RUN) && (!ir_valid_q || ir_ready_i) && !jump_en_i;
        transfer = ir_valid_q && ir_ready_i;
        is_halt  = (opcode_of(instr_i) == OPC_HALT);
        pc_inc   = load && !is_halt;
    end

    pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .load_i     (jump_act),
        .load_val_i (jump_addr_i),
        .inc_i      (pc_inc),
        .pc_o       (pc_o)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!jump_act && load && is_halt) begin
                    state_d = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (jump_act) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        halted_o = (state_q == ST_HALTED);
    end

    // A jump flushes the IR even when the decoder is consuming it this cycle.
    always_comb begin
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        if (jump_act) begin
            ir_valid_d = 1'b0;
        end else if (load) begin
            ir_d       = instr_i;
            ir_valid_d = 1'b1;
        end else if (transfer) begin
            ir_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign ir_o       = ir_q;
    assign ir_valid_o = ir_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: walks start, backpressure, jump, wrap,
// halt and mid-run reset against hand-computed expected outputs.
module tb_fetch_unit;

    logic       clk;
    logic       reset;
    logic       start_i;
    logic [3:0] pc_o;
    logic [7:0] instr_i;
    logic [7:0] ir_o;
    logic       ir_valid_o;
    logic       ir_ready_i;
    logic       jump_en_i;
    logic [3:0] jump_addr_i;
    logic       halted_o;

    logic [7:0] mem [16];

    int vectors;
    int miscompares;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start_i),
        .pc_o        (pc_o),
        .instr_i     (instr_i),
        .ir_o        (ir_o),
        .ir_valid_o  (ir_valid_o),
        .ir_ready_i  (ir_ready_i),
        .jump_en_i   (jump_en_i),
        .jump_addr_i (jump_addr_i),
        .halted_o    (halted_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instr_i = mem[pc_o];

    // Drive one cycle's inputs, let a rising edge pass, settle on the falling edge.
    task automatic applyStimulus(input logic rst, input logic start, input logic jump,
                                 input logic [3:0] addr, input logic ready);
        reset       = rst;
        start_i     = start;
        jump_en_i   = jump;
        jump_addr_i = addr;
        ir_ready_i  = ready;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] pc, input logic [7:0] ir,
                            input logic valid, input logic halted);
        checkOutput({tag, ".pc"}, {4'h0, pc_o}, {4'h0, pc});
        checkOutput({tag, ".ir"}, ir_o, ir);
        checkOutput({tag, ".valid"}, {7'h0, ir_valid_o}, {7'h0, valid});
        checkOutput({tag, ".halted"}, {7'h0, halted_o}, {7'h0, halted});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);

        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        checkAll("reset", 4'h0, 8'h00, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
        checkAll("start_edge", 4'h0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        checkAll("fetch0", 4'h1, 8'h10, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        checkAll("fetch1", 4'h2, 8'h11, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        checkAll("fetch2", 4'h3, 8'h12, 1'b1, 1'b0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
            checkAll("stall", 4'h3, 8'h12, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        checkAll("release", 4'h4, 8'h13, 1'b1, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b1, 4'hA, 1'b1);
        checkAll("jump_flush", 4'hA, 8'h13, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        checkAll("jump_target", 4'hB, 8'h1A, 1'b1, 1'b0);

        applyStimulus(1'b0, 1'b0, 1'b1, 4'hE, 1'b1);
        checkAll("wrap_jump", 4'hE, 8'h1A, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        checkAll("wrap_e", 4'hF, 8'h1E, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        checkAll("wrap_f", 4'h0, 8'h1F, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        checkAll("wrap_0", 4'h1, 8'h10, 1'b1, 1'b0);

        mem[5] = 8'hF0;
        applyStimulus(1'b0, 1'b0, 1'b1, 4'h5, 1'b1);
        checkAll("halt_jump", 4'h5, 8'h10, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        checkAll("halt_load", 4'h5, 8'hF0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        checkAll("halt_hold", 4'h5, 8'hF0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        checkAll("halt_drain", 4'h5, 8'hF0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
        checkAll("halt_start", 4'h5, 8'hF0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        checkAll("halt_idle", 4'h5, 8'hF0, 1'b0, 1'b1);

        applyStimulus(1'b0, 1'b0, 1'b1, 4'h2, 1'b1);
        checkAll("unhalt", 4'h2, 8'hF0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        checkAll("unhalt_fetch", 4'h3, 8'h12, 1'b1, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        checkAll("mid_reset", 4'h0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        checkAll("idle_noload", 4'h0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'h7, 1'b1);
        checkAll("idle_jump", 4'h0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 1'b1);
        checkAll("restart_edge", 4'h0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        checkAll("restart_fetch", 4'h1, 8'h10, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 8-bit processor.
- Owns the program counter and drives the 4-bit address into program memory, which is combinational.
- Captures the returned 8-bit instruction into an instruction register (IR) and presents it to the decoder with a valid/ready handshake.
- Handles start, jump redirect with wrong-path flush, and halt.

Parameters:
- PC_W, 4, program counter / memory address width (16-entry program space).
- INSTR_W, 8, instruction width; opcode is instr[7:4], operand is instr[3:0].
- RESET_PC, 4'h0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start_i  input  1  pulse; leaves IDLE and begins fetching.
- pc_o  output  PC_W  registered fetch address to program memory.
- instr_i  input  INSTR_W  instruction from program memory; valid in the same cycle as pc_o.
- ir_o  output  INSTR_W  registered instruction to decoder.
- ir_valid_o  output  1  ir_o holds an unconsumed instruction.
- ir_ready_i  input  1  decoder accepts ir_o this cycle.
- jump_en_i  input  1  redirect request from decoder/execute.
- jump_addr_i  input  PC_W  jump target.
- halted_o  output  1  high while in HALTED.

Behaviour:
- Reset: the clock and reset are one clock; reset is synchronous and active-high. Resets are sampled on the rising edge of clk; reset has priority over all other inputs.
- Reset values: pc_o=RESET_PC, ir_o=0, ir_valid_o=0, halted_o=0, state=IDLE. This applies identically when reset is asserted mid-operation, and any in-flight IR content is discarded.
- States: IDLE, RUN, HALTED (2-bit encoding from the package).
- IDLE:
  - No loads.
  - start_i -> RUN next cycle.
  - jump_en_i is ignored.
- Handshake: a transfer occurs when ir_valid_o && ir_ready_i. ir_o is stable while ir_valid_o=1 and no transfer has occurred.
- load = (state==RUN) && (!ir_valid_o || ir_ready_i) && !jump_en_i. Throughput is one instruction per cycle when ready is held high.
- On load:
  - ir_o <= instr_i, ir_valid_o <= 1.
  - pc_o <= pc_o+1, modulo 2^PC_W (15 -> 0 wrap, no flag).
- Transfer without load (RUN or HALTED): ir_valid_o <= 0.
- HALT: when the loaded instr_i[7:4]==OPC_HALT (4'hF):
  - The HALT instruction is still delivered to the decoder.
  - pc_o is NOT incremented and stays pointing at the HALT instruction.
  - state <= HALTED, halted_o <= 1 the next cycle.
- HALTED:
  - No further loads; the pending IR is drained normally via the handshake.
  - start_i is ignored.
- jump_en_i in RUN or HALTED:
  - pc_o <= jump_addr_i, ir_valid_o <= 0 (flush, even if ready was high).
  - state <= RUN, halted_o <= 0.
  - The target instruction is loaded in the following cycle, so jump-to-valid latency is 2 cycles.
- Priority: reset > jump_en_i > load > transfer-only. If jump_en_i and a transfer coincide, the instruction counts as consumed and the flush still applies.
- start_i in RUN is ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - PC_W, INSTR_W.
  - The opcode field slice positions.
  - OPC_HALT=4'hF.
  - The fetch state enum/localparams (ST_IDLE=0, ST_RUN=1, ST_HALTED=2).
- Optional sub-module pc_reg: a PC register with synchronous reset, load (jump), increment, and hold inputs. The FSM and IR stay in fetch_unit.
- No other sub-modules.

Test Plan:
The bench uses a 16-entry combinational memory model with mem[i]=8'h10+i, except where a test overrides it.
- Reset then start_i pulse, ready=1 -> ir_o = 8'h10, 8'h11, 8'h12 ... on consecutive cycles; pc_o = 1, 2, 3.
- Backpressure: ready=0 for 3 cycles after ir_o=8'h12 -> ir_o holds 8'h12, valid stays 1, pc_o holds 3. Release ready -> 8'h13 is delivered next.
- Jump: jump_en_i=1 with jump_addr_i=4'hA -> ir_valid_o=0 next cycle, pc_o=A; the cycle after that, ir_o=8'h1A and valid=1.
- Wrap: run from pc 4'hE -> ir_o 8'h1E, 8'h1F, 8'h10; pc_o wraps 0xF -> 0x0 -> 0x1.
- Halt: mem[5]=8'hF0 -> 8'hF0 is delivered, halted_o=1, pc_o stays 5, no new valid after the handshake. Then jump_en_i to 4'h2 -> halted_o=0 and ir_o=8'h12 follows.
- Reset mid-RUN with ir_valid_o=1 -> the next cycle shows all outputs at reset values, state IDLE, and no loads until start_i.
